// File: rtl/imsic_msi_sender.sv
// IMSIC MSI sender: queues legal MSI requests and replays each one to the IMSIC
// as a slow level strobe carrying {hart_id, file, setipnum}.
module imsic_msi_sender #(
    parameter int NR_INTP_FILES  = 7,
    parameter int NR_HARTS_WIDTH = 2,
    parameter int NR_SRC         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int HIGH_CYC       = 4,
    parameter int LOW_CYC        = 4,
    localparam int NR_SRC_WIDTH    = $clog2(NR_SRC),
    localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
    localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_msi_req_vld,
    output logic                       o_msi_req_rdy,
    input  logic [NR_HARTS_WIDTH-1:0]  i_msi_hart_id,
    input  logic [INTP_FILE_WIDTH-1:0] i_msi_file,
    input  logic [NR_SRC_WIDTH-1:0]    i_msi_setipnum,
    output logic [MSI_INFO_WIDTH-1:0]  o_msi_info,
    output logic                       o_msi_info_vld,
    output logic                       o_busy,
    output logic [7:0]                 o_drop_cnt
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PH_MAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t state, state_nxt;
    logic [PH_W-1:0] cnt, cnt_nxt;

    logic [MSI_INFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic fifo_empty, fifo_full, fifo_avail;
    logic req_fire, req_legal, push, drop, pop;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign o_msi_req_rdy = !fifo_full;
    assign o_busy        = !fifo_empty || (state != IDLE);

    assign req_legal = (i_msi_setipnum != '0)
                    && (int'(i_msi_setipnum) < NR_SRC)
                    && (int'(i_msi_file) < NR_INTP_FILES);
    assign req_fire  = i_msi_req_vld && o_msi_req_rdy;
    assign push      = req_fire && req_legal;
    assign drop      = req_fire && !req_legal;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= {i_msi_hart_id, i_msi_file, i_msi_setipnum};
        end
    end

    // fifo_avail is a registered copy of "non-empty"; it is only consulted from IDLE,
    // which is always at least HIGH_CYC+LOW_CYC cycles after the last pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_avail <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            fifo_avail <= !fifo_empty;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_drop_cnt <= 8'd0;
        end else if (drop && (o_drop_cnt != 8'hFF)) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_avail) begin
                    pop       = 1'b1;
                    state_nxt = HIGH;
                    cnt_nxt   = PH_W'(HIGH_CYC - 1);
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_nxt = LOW;
                    cnt_nxt   = PH_W'(LOW_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Info only moves on the pop edge so the receiver sees it stable around vld's fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_msi_info     <= '0;
            o_msi_info_vld <= 1'b0;
        end else begin
            if (pop) begin
                o_msi_info <= mem[rptr[AW-1:0]];
            end
            o_msi_info_vld <= (state_nxt == HIGH);
        end
    end

endmodule

// File: tb/tb_imsic_msi_sender.sv
// Self-checking bench for imsic_msi_sender: directed scenarios plus random traffic,
// compared every cycle against a timestamp-based model of message delivery.
module tb_imsic_msi_sender;

    localparam int NR_FILES = 7;
    localparam int NR_SRC   = 32;
    localparam int DEPTH    = 4;
    localparam int HIGH_CYC = 4;
    localparam int LOW_CYC  = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       i_msi_req_vld = 1'b0;
    logic       o_msi_req_rdy;
    logic [1:0] i_msi_hart_id = '0;
    logic [2:0] i_msi_file = '0;
    logic [4:0] i_msi_setipnum = '0;
    logic [9:0] o_msi_info;
    logic       o_msi_info_vld;
    logic       o_busy;
    logic [7:0] o_drop_cnt;

    imsic_msi_sender dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_msi_req_vld  (i_msi_req_vld),
        .o_msi_req_rdy  (o_msi_req_rdy),
        .i_msi_hart_id  (i_msi_hart_id),
        .i_msi_file     (i_msi_file),
        .i_msi_setipnum (i_msi_setipnum),
        .o_msi_info     (o_msi_info),
        .o_msi_info_vld (o_msi_info_vld),
        .o_busy         (o_busy),
        .o_drop_cnt     (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: pending entries with their accept edge; a message starts at the later of
    // accept+2 and previous start + HIGH_CYC+LOW_CYC+1.
    int         e = 0;
    int         ls = -1000;
    logic [9:0] cur_info = '0;
    int         drops = 0;
    logic [9:0] q_info[$];
    int         q_acc[$];
    logic       model_acc;
    logic       req_v;
    int         req_hart, req_file, req_ip;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, e, got, exp);
        end
    endtask

    task automatic modelReset();
        q_info.delete();
        q_acc.delete();
        ls = -1000;
        cur_info = '0;
        drops = 0;
    endtask

    task automatic modelEdge();
        int occ;
        occ = q_info.size();
        e++;
        model_acc = 1'b0;
        if (q_info.size() > 0 && q_acc[0] + 2 <= e && e >= ls + HIGH_CYC + LOW_CYC + 1) begin
            ls = e;
            cur_info = q_info.pop_front();
            void'(q_acc.pop_front());
        end
        if (req_v && occ < DEPTH) begin
            model_acc = 1'b1;
            if (req_ip == 0 || req_ip >= NR_SRC || req_file >= NR_FILES) begin
                if (drops < 255) drops++;
            end else begin
                q_info.push_back({req_hart[1:0], req_file[2:0], req_ip[4:0]});
                q_acc.push_back(e);
            end
        end
    endtask

    task automatic checkOutput();
        check("vld",  32'(o_msi_info_vld), 32'((e - ls) < HIGH_CYC));
        check("info", 32'(o_msi_info), 32'(cur_info));
        check("rdy",  32'(o_msi_req_rdy), 32'(q_info.size() < DEPTH));
        check("busy", 32'(o_busy), 32'(q_info.size() > 0 || (e - ls) < HIGH_CYC + LOW_CYC));
        check("drop", 32'(o_drop_cnt), 32'(drops));
    endtask

    task automatic applyStimulus(input logic v, input int hart, input int file, input int ip);
        i_msi_req_vld  = v;
        i_msi_hart_id  = 2'(hart);
        i_msi_file     = 3'(file);
        i_msi_setipnum = 5'(ip);
        req_v = v;
        req_hart = hart;
        req_file = file;
        req_ip = ip;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0);
    endtask

    task automatic doReset();
        rstn = 1'b0;
        i_msi_req_vld = 1'b0;
        req_v = 1'b0;
        modelReset();
        #1;
        check("rst_vld",  32'(o_msi_info_vld), 32'd0);
        check("rst_info", 32'(o_msi_info), 32'd0);
        check("rst_rdy",  32'(o_msi_req_rdy), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_drop", 32'(o_drop_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        req_v = 1'b0;
        #2;
        doReset();

        // Single request: hart 2, file 1, setipnum 5
        applyStimulus(1'b1, 2, 1, 5);
        applyStimulus(1'b0, 0, 0, 0);
        check("single_lat_low", 32'(o_msi_info_vld), 32'd0);
        applyStimulus(1'b0, 0, 0, 0);
        check("single_info", 32'(o_msi_info), 32'h225);
        check("single_vld", 32'(o_msi_info_vld), 32'd1);
        idle(8);
        check("single_idle", 32'(o_busy), 32'd0);

        // Burst of 6 held valid until accepted
        for (int k = 0; k < 6; k++) begin
            int tries;
            tries = 0;
            do begin
                applyStimulus(1'b1, k % 4, k % 7, k + 1);
                tries++;
            end while (!model_acc && tries < 60);
            if (!model_acc) check("burst_timeout", 32'd1, 32'd0);
        end
        idle(60);

        // Illegal drops
        applyStimulus(1'b1, 1, 2, 0);
        applyStimulus(1'b1, 1, 2, 32);
        applyStimulus(1'b1, 1, 7, 9);
        idle(4);
        check("drop3", 32'(o_drop_cnt), 32'd3);

        // Push coinciding with the pop of a single queued entry
        applyStimulus(1'b1, 3, 2, 17);
        applyStimulus(1'b0, 0, 0, 0);
        applyStimulus(1'b1, 0, 4, 30);
        idle(25);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 2) != 0, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
        end
        idle(60);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 0, 0, 0);
        check("drop_sat", 32'(o_drop_cnt), 32'd255);

        // Reset in the second HIGH cycle with two entries still queued
        applyStimulus(1'b1, 1, 1, 1);
        applyStimulus(1'b1, 2, 2, 2);
        applyStimulus(1'b1, 3, 3, 3);
        applyStimulus(1'b0, 0, 0, 0);
        check("pre_rst_vld", 32'(o_msi_info_vld), 32'd1);
        doReset();
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
